// File: rtl/l1_meta_lookup.sv
// L1 metadata lookup pipeline.
// A request reads one set of the tag array; the following cycle (S1) compares
// the 8 returned ways against the request tag, picks a replacement victim
// (first invalid way, else tree-PLRU), updates the set's PLRU and pushes the
// result into a 2-entry response FIFO whose head drives the resp_* outputs.
module l1_meta_lookup (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [5:0]   req_idx,
    input  logic [20:0]  req_tag,
    output logic         meta_read_valid,
    input  logic         meta_read_ready,
    output logic [5:0]   meta_read_idx,
    input  logic [183:0] meta_resp_data,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_hit,
    output logic [7:0]   resp_way_en,
    output logic [1:0]   resp_coh_state,
    output logic [7:0]   resp_victim_en,
    output logic [20:0]  resp_victim_tag,
    output logic [1:0]   resp_victim_coh_state
);

    typedef struct packed {
        logic        hit;
        logic [7:0]  way_en;
        logic [1:0]  coh;
        logic [7:0]  victim_en;
        logic [20:0] victim_tag;
        logic [1:0]  victim_coh;
    } result_t;

    // Tree-PLRU victim: b0 root, b1/b2 halves, b3..b6 pairs; 0 points low.
    function automatic logic [2:0] plru_victim(input logic [6:0] b);
        logic [2:0] v;
        v[2] = b[0];
        if (b[0] == 1'b0) begin
            v[1] = b[1];
            v[0] = b[1] ? b[4] : b[3];
        end else begin
            v[1] = b[2];
            v[0] = b[2] ? b[6] : b[5];
        end
        return v;
    endfunction

    // Make every node on the path of way w point away from it.
    function automatic logic [6:0] plru_touch(input logic [6:0] b, input logic [2:0] w);
        logic [6:0] n;
        n    = b;
        n[0] = ~w[2];
        if (w[2] == 1'b0) begin
            n[1] = ~w[1];
            if (w[1]) n[4] = ~w[0];
            else      n[3] = ~w[0];
        end else begin
            n[2] = ~w[1];
            if (w[1]) n[6] = ~w[0];
            else      n[5] = ~w[0];
        end
        return n;
    endfunction

    logic        s1_valid_r;
    logic [5:0]  s1_idx_r;
    logic [20:0] s1_tag_r;
    logic [6:0]  plru_r [64];
    result_t     fifo_r [2];
    logic [1:0]  fifo_count_r;

    logic        resp_fire_s;
    logic        req_fire_s;
    logic        can_accept_s;
    logic [2:0]  occupancy_s;
    logic [1:0]  way_coh_s [8];
    logic [20:0] way_tag_s [8];
    logic        hit_s;
    logic [2:0]  hit_way_s;
    logic        inv_found_s;
    logic [2:0]  inv_way_s;
    logic [2:0]  victim_way_s;
    logic [2:0]  touch_way_s;
    result_t     result_s;

    // Occupancy counts the S1 slot plus FIFO entries, net of this cycle's pop,
    // so an accepted request always finds room when it reaches the FIFO.
    assign resp_valid      = (fifo_count_r != 2'd0) & ~reset;
    assign resp_fire_s     = resp_valid & resp_ready;
    assign occupancy_s     = {2'b00, s1_valid_r} + {1'b0, fifo_count_r} - {2'b00, resp_fire_s};
    assign can_accept_s    = (occupancy_s < 3'd2) & ~reset;
    assign meta_read_valid = req_valid & can_accept_s;
    assign req_ready       = meta_read_ready & can_accept_s;
    assign meta_read_idx   = req_idx;
    assign req_fire_s      = req_valid & req_ready;

    // Unpack ways and find the lowest matching way and lowest invalid way.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = 3'd0;
        inv_found_s = 1'b0;
        inv_way_s   = 3'd0;
        for (int w = 7; w >= 0; w--) begin
            way_coh_s[w] = meta_resp_data[23*w+21 +: 2];
            way_tag_s[w] = meta_resp_data[23*w +: 21];
            if ((way_coh_s[w] != 2'd0) && (way_tag_s[w] == s1_tag_r)) begin
                hit_s     = 1'b1;
                hit_way_s = 3'(w);
            end else begin
                hit_s     = hit_s;
            end
            if (way_coh_s[w] == 2'd0) begin
                inv_found_s = 1'b1;
                inv_way_s   = 3'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
    end

    // Victim choice, PLRU touch target and the packed S1 result.
    always_comb begin
        if (inv_found_s) begin
            victim_way_s = inv_way_s;
        end else begin
            victim_way_s = plru_victim(plru_r[s1_idx_r]);
        end
        touch_way_s         = hit_s ? hit_way_s : victim_way_s;
        result_s.hit        = hit_s;
        result_s.way_en     = hit_s ? (8'd1 << hit_way_s) : 8'd0;
        result_s.coh        = hit_s ? way_coh_s[hit_way_s] : 2'd0;
        result_s.victim_en  = 8'd1 << victim_way_s;
        result_s.victim_tag = way_tag_s[victim_way_s];
        result_s.victim_coh = way_coh_s[victim_way_s];
    end

    // S1 stage register: one lookup in flight behind the array read.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_idx_r   <= 6'd0;
            s1_tag_r   <= 21'd0;
        end else begin
            s1_valid_r <= req_fire_s;
            if (req_fire_s) begin
                s1_idx_r <= req_idx;
                s1_tag_r <= req_tag;
            end
        end
    end

    // PLRU update at the end of S1; read combinationally so the next lookup sees it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < 64; s++) begin
                plru_r[s] <= 7'd0;
            end
        end else if (s1_valid_r) begin
            plru_r[s1_idx_r] <= plru_touch(plru_r[s1_idx_r], touch_way_s);
        end
    end

    // Shifting 2-entry response FIFO; entry 0 is the head, unused slots kept at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            fifo_count_r <= 2'd0;
            fifo_r[0]    <= '0;
            fifo_r[1]    <= '0;
        end else begin
            case ({s1_valid_r, resp_fire_s})
                2'b10: begin
                    if (fifo_count_r == 2'd0) fifo_r[0] <= result_s;
                    else                      fifo_r[1] <= result_s;
                    fifo_count_r <= fifo_count_r + 2'd1;
                end
                2'b01: begin
                    fifo_r[0]    <= fifo_r[1];
                    fifo_r[1]    <= '0;
                    fifo_count_r <= fifo_count_r - 2'd1;
                end
                2'b11: begin
                    if (fifo_count_r == 2'd1) begin
                        fifo_r[0] <= result_s;
                    end else begin
                        fifo_r[0] <= fifo_r[1];
                        fifo_r[1] <= result_s;
                    end
                end
                default: begin
                    fifo_count_r <= fifo_count_r;
                end
            endcase
        end
    end

    assign resp_hit              = fifo_r[0].hit;
    assign resp_way_en           = fifo_r[0].way_en;
    assign resp_coh_state        = fifo_r[0].coh;
    assign resp_victim_en        = fifo_r[0].victim_en;
    assign resp_victim_tag       = fifo_r[0].victim_tag;
    assign resp_victim_coh_state = fifo_r[0].victim_coh;

endmodule
